// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants and state encoding for the serial tape link
package serial_pkg;

  localparam int         FRAME_BITS  = 10;
  localparam logic [7:0] LEADER_BYTE = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    LEADER,
    BODY,
    TRAILER
  } tape_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 transmit core: baud counter, frame shift register, bit counter
module uart_tx_core
  import serial_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  output logic       ready,
  output logic       tx
);

  localparam int              BW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(DIV - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(FRAME_BITS - 1);

  logic                  active_q, active_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  bit_end;

  // The line is the LSB of the shift register; ones fill in behind, so idle is mark.
  assign tx      = shift_q[0];
  assign bit_end = active_q && (baud_q == BAUD_LAST);
  assign ready   = !active_q || (bit_end && (bit_q == BIT_LAST));

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    if (load && ready) begin
      shift_d  = {1'b1, din, 1'b0};
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
    end else if (bit_end) begin
      baud_d  = '0;
      shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
      if (bit_q == BIT_LAST) begin
        active_d = 1'b0;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else if (active_q) begin
      baud_d = baud_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: rtl/tape_reader_tx.sv
// rtl/tape_reader_tx.sv - paper-tape emulator framing leader, body and trailer onto the rx line
module tape_reader_tx
  import serial_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int LEADER_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int            DIV   = CLK_FREQ / BAUD;
  localparam int            CW    = (LEADER_LEN > 0) ? $clog2(LEADER_LEN + 1) : 1;
  localparam logic [CW-1:0] LEN_C = CW'(LEADER_LEN);

  tape_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          core_load, core_ready;
  logic [7:0]    core_din;

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    core_load  = 1'b0;
    core_din   = LEADER_BYTE;
    data_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // Accepted start spends one cycle in IDLE with busy set before the first load.
        if (busy_q) begin
          state_d = (LEADER_LEN == 0) ? BODY : LEADER;
          cnt_d   = '0;
        end else if (start) begin
          busy_d = 1'b1;
        end
      end
      LEADER: begin
        if (core_ready) begin
          core_load = 1'b1;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == LEN_C - CW'(1)) begin
            state_d = BODY;
            cnt_d   = '0;
          end
        end
      end
      BODY: begin
        data_ready = core_ready;
        core_din   = data_in;
        if (data_valid && core_ready) begin
          core_load = 1'b1;
          if (data_last) begin
            state_d = TRAILER;
            cnt_d   = '0;
          end
        end
      end
      TRAILER: begin
        // With every trailer byte queued, core_ready marks the final stop-bit clock.
        if (cnt_q == LEN_C) begin
          if (core_ready) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (core_ready) begin
          core_load = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_core #(
    .DIV(DIV)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .load (core_load),
    .din  (core_din),
    .ready(core_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_tape_reader_tx.sv
// tb/tb_tape_reader_tx.sv - directed bench for tape_reader_tx with a reference 8N1 receiver
module tb_tape_reader_tx;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [7:0] data_in;
  logic       valid_a, valid_b;
  logic       data_last;
  logic       ready_a, ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t0;

  logic [7:0] rx_mem  [2][16];
  logic [7:0] rx_sh   [2];
  logic       rx_busy [2] = '{1'b0, 1'b0};
  int         rx_cnt  [2] = '{0, 0};
  int         rx_n    [2] = '{0, 0};
  int         rx_err  [2] = '{0, 0};
  int         done_n  [2] = '{0, 0};

  logic [7:0] exp_a [6] = '{8'h80, 8'h80, 8'h5A, 8'hA5, 8'h80, 8'h80};
  logic [7:0] exp_r [5] = '{8'h80, 8'h80, 8'h3C, 8'h80, 8'h80};

  tape_reader_tx #(.CLK_FREQ(40), .BAUD(10), .LEADER_LEN(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .data_in(data_in),
    .data_valid(valid_a), .data_last(data_last), .data_ready(ready_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  tape_reader_tx #(.CLK_FREQ(40), .BAUD(10), .LEADER_LEN(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .data_in(data_in),
    .data_valid(valid_b), .data_last(data_last), .data_ready(ready_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Receiver: start detected at the first low sample, data sampled mid-bit.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic txv;
      txv = (i == 0) ? tx_a : tx_b;
      if (reset) begin
        rx_busy[i] = 1'b0;
      end else begin
        if ((i == 0) ? done_a : done_b) done_n[i]++;
        if (!rx_busy[i]) begin
          if (txv == 1'b0) begin
            rx_busy[i] = 1'b1;
            rx_cnt[i]  = 0;
          end
        end else begin
          rx_cnt[i]++;
          if (rx_cnt[i] == DIV/2 && txv !== 1'b0) rx_err[i]++;
          if (rx_cnt[i] >= DIV + DIV/2 && rx_cnt[i] <= 8*DIV + DIV/2 && (rx_cnt[i] % DIV) == DIV/2)
            rx_sh[i] = {txv, rx_sh[i][7:1]};
          if (rx_cnt[i] == 9*DIV + DIV/2) begin
            if (txv !== 1'b1) rx_err[i]++;
            if (rx_n[i] < 16) rx_mem[i][rx_n[i]] = rx_sh[i];
            rx_n[i]++;
          end
          if (rx_cnt[i] == 10*DIV - 1) rx_busy[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return ready_a;
      1:       return done_a;
      2:       return ready_b;
      3:       return done_b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_hi(input int sel, input string tag);
    int n = 0;
    while (sig(sel) !== 1'b1 && n < 500) begin
      tick(1);
      n++;
    end
    chk(tag, {31'd0, sig(sel)}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; data_in = 8'h00; data_last = 1'b0;

    repeat (3) begin
      tick(1);
      chk("rst_tx_a", tx_a, 1);     chk("rst_busy_a", busy_a, 0);
      chk("rst_ready_a", ready_a, 0); chk("rst_done_a", done_a, 0);
      chk("rst_tx_b", tx_b, 1);     chk("rst_busy_b", busy_b, 0);
      chk("rst_ready_b", ready_b, 0); chk("rst_done_b", done_b, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("idle_tx_a", tx_a, 1);
      chk("idle_tx_b", tx_b, 1);
    end

    // Leader + body + trailer, with a second start during the leader
    data_in = 8'h5A; valid_a = 1'b1; data_last = 1'b0;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    chk("busy_after_start", busy_a, 1);
    chk("tx_edge_k", tx_a, 1);
    tick(1);
    chk("tx_edge_k1", tx_a, 1);
    chk("ready_outside_body", ready_a, 0);
    tick(1);
    chk("tx_edge_k2", tx_a, 0);
    t0 = cyc;
    tick(20);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    chk("busy_ignored_start", busy_a, 1);
    wait_hi(0, "wait_ready_1");
    chk("ready_first_rise", cyc - t0, 79);
    tick(1);
    data_in = 8'hA5; data_last = 1'b1;
    wait_hi(0, "wait_ready_2");
    chk("ready_second_rise", cyc - t0, 119);
    tick(1);
    valid_a = 1'b0; data_last = 1'b0;
    wait_hi(1, "wait_done_a");
    chk("done_time", cyc - t0, 240);
    chk("busy_drop_with_done", busy_a, 0);
    tick(1);
    chk("done_one_clock", done_a, 0);
    chk("tape_a_len", rx_n[0], 6);
    for (int i = 0; i < 6; i++) chk($sformatf("tape_a_byte%0d", i), rx_mem[0][i], exp_a[i]);
    chk("done_count_a", done_n[0], 1);
    chk("frame_err_a", rx_err[0], 0);

    // No leader, body stall
    data_in = 8'h01; valid_b = 1'b1; data_last = 1'b0;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    wait_hi(2, "wait_ready_b1");
    tick(1);
    valid_b = 1'b0;
    chk("tx_b_start", tx_b, 0);
    wait_hi(2, "wait_ready_b2");
    for (int i = 0; i < 37; i++) begin
      tick(1);
      chk("stall_tx_b", tx_b, 1);
      chk("stall_ready_b", ready_b, 1);
    end
    data_in = 8'hFF; data_last = 1'b1; valid_b = 1'b1;
    tick(1);
    valid_b = 1'b0; data_last = 1'b0;
    wait_hi(3, "wait_done_b");
    chk("busy_b_done", busy_b, 0);
    tick(1);
    chk("tape_b_len", rx_n[1], 2);
    chk("tape_b_byte0", rx_mem[1][0], 8'h01);
    chk("tape_b_byte1", rx_mem[1][1], 8'hFF);
    chk("done_count_b", done_n[1], 1);
    chk("frame_err_b", rx_err[1], 0);

    // Reset during data bit 3 of a body byte
    rx_n[0] = 0;
    data_in = 8'hC3; valid_a = 1'b1; data_last = 1'b1;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    wait_hi(0, "wait_ready_r");
    tick(1);
    tick(17);
    reset = 1'b1; valid_a = 1'b0; data_last = 1'b0;
    tick(1);
    chk("midrst_tx", tx_a, 1);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_ready", ready_a, 0);
    reset = 1'b0;
    tick(50);
    chk("midrst_no_done", done_n[0], 1);
    chk("midrst_tape_len", rx_n[0], 2);

    rx_n[0] = 0;
    data_in = 8'h3C; valid_a = 1'b1; data_last = 1'b1;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    wait_hi(0, "wait_ready_f");
    tick(1);
    valid_a = 1'b0; data_last = 1'b0;
    wait_hi(1, "wait_done_f");
    tick(1);
    chk("fresh_tape_len", rx_n[0], 5);
    for (int i = 0; i < 5; i++) chk($sformatf("fresh_byte%0d", i), rx_mem[0][i], exp_r[i]);
    chk("fresh_done_count", done_n[0], 2);
    chk("fresh_frame_err", rx_err[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
